// File: rtl/steering_link_tx.sv
// UART transmitter for the steering command: sends a 4-byte checksummed frame
// (A5, flags/dir[8], dir[7:0], xor) on every command change and as a keep-alive.
module steering_link_tx #(
   parameter int CLK_HZ         = 50_000_000,
   parameter int BAUD           = 115200,
   parameter int REFRESH_CYCLES = 500_000
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic [8:0]  targetDirection_Ard,
   input  logic        reset_Pos_Ard,
   output logic        tx,
   output logic        busy,
   output logic [15:0] frames_sent
);

   localparam int DIV    = CLK_HZ / BAUD;
   localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
   localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [REF_W-1:0]  refresh_cnt;
   logic [2:0]        bit_idx;
   logic [1:0]        byte_idx;
   logic              sent_valid;
   logic [8:0]        snap_dir;
   logic              snap_pos;
   logic [7:0]        cur_byte;
   logic              bit_end;
   logic              trigger;

   function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                             input logic       pos,
                                             input logic [8:0] dir);
      logic [7:0] b1;
      logic [7:0] b2;
      b1 = {pos, 6'b0, dir[8]};
      b2 = dir[7:0];
      case (idx)
         2'd0:    frame_byte = 8'hA5;
         2'd1:    frame_byte = b1;
         2'd2:    frame_byte = b2;
         default: frame_byte = b1 ^ b2;
      endcase
   endfunction

   function automatic logic [REF_W-1:0] sat_inc_refresh(input logic [REF_W-1:0] cnt);
      sat_inc_refresh = (cnt == REF_LAST) ? cnt : cnt + REF_W'(1);
   endfunction

   // Payload always comes from the snapshot so a frame in flight is immune to input changes
   assign cur_byte = frame_byte(byte_idx, snap_pos, snap_dir);
   assign bit_end  = (baud_cnt == BAUD_LAST);
   assign trigger  = !sent_valid
                  || ({reset_Pos_Ard, targetDirection_Ard} != {snap_pos, snap_dir})
                  || (refresh_cnt == REF_LAST);

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         tx          <= 1'b1;
         busy        <= 1'b0;
         frames_sent <= 16'd0;
         baud_cnt    <= '0;
         refresh_cnt <= '0;
         bit_idx     <= 3'd0;
         byte_idx    <= 2'd0;
         sent_valid  <= 1'b0;
         snap_dir    <= 9'd0;
         snap_pos    <= 1'b0;
      end else begin
         if (state == S_IDLE && trigger)
            refresh_cnt <= '0;
         else
            refresh_cnt <= sat_inc_refresh(refresh_cnt);

         if (state != S_IDLE)
            baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);

         case (state)
            S_IDLE: begin
               if (trigger) begin
                  snap_dir   <= targetDirection_Ard;
                  snap_pos   <= reset_Pos_Ard;
                  sent_valid <= 1'b1;
                  byte_idx   <= 2'd0;
                  baud_cnt   <= '0;
                  tx         <= 1'b0;
                  busy       <= 1'b1;
                  state      <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  tx      <= cur_byte[0];
                  bit_idx <= 3'd0;
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     tx      <= cur_byte[bit_idx + 3'd1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            default: begin
               if (bit_end) begin
                  if (byte_idx == 2'd3) begin
                     busy        <= 1'b0;
                     frames_sent <= frames_sent + 16'd1;
                     state       <= S_IDLE;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                     tx       <= 1'b0;
                     state    <= S_START;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_steering_link_tx.sv
// Directed bench for steering_link_tx: decodes the UART line into frames and
// checks payloads, timing, keep-alive spacing, reset and counter wrap.
module tb_steering_link_tx;

   logic        CLOCK_50;
   logic        reset_n;
   logic [8:0]  targetDirection_Ard;
   logic        reset_Pos_Ard;
   logic        tx;
   logic        busy;
   logic [15:0] frames_sent;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int          cyc   = 0;

   steering_link_tx #(
      .CLK_HZ(1_000_000),
      .BAUD(250_000),
      .REFRESH_CYCLES(1000)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .reset_n(reset_n),
      .targetDirection_Ard(targetDirection_Ard),
      .reset_Pos_Ard(reset_Pos_Ard),
      .tx(tx),
      .busy(busy),
      .frames_sent(frames_sent)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // Line decoder: samples mid-bit at DIV=4, assembles 4-byte frames
   logic        rx_active = 1'b0;
   int          rx_cnt    = 0;
   logic [7:0]  rx_sh     = 8'h00;
   logic [23:0] frame_sh  = 24'h0;
   logic [1:0]  byte_n    = 2'd0;
   logic [31:0] frame_q[$];

   always @(negedge CLOCK_50) begin
      if (!reset_n) begin
         rx_active <= 1'b0;
         rx_cnt    <= 0;
         byte_n    <= 2'd0;
      end else if (!rx_active) begin
         if (tx == 1'b0) begin
            rx_active <= 1'b1;
            rx_cnt    <= 1;
         end
      end else begin
         rx_cnt <= rx_cnt + 1;
         if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2)
            rx_sh <= {tx, rx_sh[7:1]};
         if (rx_cnt == 39) begin
            rx_active <= 1'b0;
            frame_sh  <= {frame_sh[15:0], rx_sh};
            byte_n    <= byte_n + 2'd1;
            if (byte_n == 2'd3)
               frame_q.push_back({frame_sh, rx_sh});
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] pop_frame();
      if (frame_q.size() == 0) return 32'hDEAD0000;
      return frame_q.pop_front();
   endfunction

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic wait_end(output int len);
      len = 0;
      while (busy && len < 2000) begin
         len++;
         step();
      end
   endtask

   task automatic wait_rise(input string tag, output int t);
      int n;
      n = 0;
      while (!busy && n < 2000) begin
         n++;
         step();
      end
      chk(tag, {31'd0, busy}, 32'd1);
      t = cyc;
   endtask

   int len;
   int t0;
   int t1;
   int exp_frames;

   initial begin
      reset_n             = 1'b0;
      targetDirection_Ard = 9'd300;
      reset_Pos_Ard       = 1'b0;
      repeat (3) step();
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_frames", {16'd0, frames_sent}, 32'd0);

      // 1: frame right after reset release
      reset_n = 1'b1;
      step();
      chk("post_rst_tx_low", {31'd0, tx}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd1);
      wait_end(len);
      chk("post_rst_busy_len", len, 32'd160);
      chk("post_rst_frame", pop_frame(), 32'hA5012C2D);
      exp_frames = 1;
      chk("post_rst_count", {16'd0, frames_sent}, exp_frames);

      // 2: change-driven frame, then keep-alive 1000 cycles later
      reset_Pos_Ard = 1'b1;
      step();
      chk("chg_start", {31'd0, busy}, 32'd1);
      chk("chg_tx_low", {31'd0, tx}, 32'd0);
      t0 = cyc;
      wait_end(len);
      chk("chg_busy_len", len, 32'd160);
      chk("chg_frame", pop_frame(), 32'hA5812CAD);
      exp_frames++;
      chk("chg_count", {16'd0, frames_sent}, exp_frames);
      wait_rise("ka1_timeout", t1);
      chk("ka1_gap", t1 - t0, 32'd1000);
      wait_end(len);
      chk("ka1_frame", pop_frame(), 32'hA5812CAD);
      exp_frames++;
      chk("ka1_count", {16'd0, frames_sent}, exp_frames);

      // 3: direction changes during B1's start bit
      reset_Pos_Ard = 1'b0;
      step();
      chk("mid_start", {31'd0, busy}, 32'd1);
      repeat (41) step();
      targetDirection_Ard = 9'd5;
      wait_end(len);
      chk("mid_frame_unchanged", pop_frame(), 32'hA5012C2D);
      exp_frames++;
      step();
      chk("mid_restart_1cyc", {31'd0, busy}, 32'd1);
      t0 = cyc;
      wait_end(len);
      chk("mid_new_frame", pop_frame(), 32'hA5000505);
      exp_frames++;
      chk("mid_count", {16'd0, frames_sent}, exp_frames);

      // 4: keep-alive with constant inputs
      for (int i = 0; i < 4; i++) begin
         wait_rise("ka_timeout", t1);
         chk("ka_gap", t1 - t0, 32'd1000);
         t0 = t1;
         wait_end(len);
         chk("ka_frame", pop_frame(), 32'hA5000505);
         exp_frames++;
         chk("ka_count", {16'd0, frames_sent}, exp_frames);
      end

      // 5: reset asserted during B2's data bits
      wait_rise("rst_mid_timeout", t1);
      repeat (90) step();
      reset_n = 1'b0;
      step();
      chk("rst_mid_tx", {31'd0, tx}, 32'd1);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_frames", {16'd0, frames_sent}, 32'd0);
      repeat (2) step();
      reset_n = 1'b1;
      step();
      chk("rst_rel_start", {31'd0, busy}, 32'd1);
      wait_end(len);
      chk("rst_rel_busy_len", len, 32'd160);
      chk("rst_rel_frame", pop_frame(), 32'hA5000505);
      chk("rst_rel_count", {16'd0, frames_sent}, 32'd1);

      // 6: frames_sent wraps from 0xFFFF to 0
      force dut.frames_sent = 16'hFFFF;
      step();
      release dut.frames_sent;
      step();
      chk("wrap_preload", {16'd0, frames_sent}, 32'h0000FFFF);
      targetDirection_Ard = 9'd511;
      reset_Pos_Ard       = 1'b1;
      step();
      chk("wrap_start", {31'd0, busy}, 32'd1);
      wait_end(len);
      chk("wrap_frame", pop_frame(), 32'hA581FF7E);
      chk("wrap_count", {16'd0, frames_sent}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/steering_link_tx.md
# steering_link_tx

Serial transmitter that sits directly downstream of the steering output register and carries the registered steering command (`targetDirection_Ard`, `reset_Pos_Ard`) to the Arduino over a single UART line. It sends a 4-byte checksummed frame whenever the command changes, and also sends a keep-alive frame at a fixed refresh interval. This gives the Arduino both a low-latency update and a watchdog heartbeat.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: UART bit rate. `DIV = CLK_HZ / BAUD`, integer floor; `DIV` must be ≥ 2.
- `REFRESH_CYCLES`, 500_000: maximum number of idle cycles between frames (10 ms at 50 MHz); must be ≥ 2.

Ports:
- `CLOCK_50`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `targetDirection_Ard`  in  9  steering command, unsigned 0–511.
- `reset_Pos_Ard`  in  1  position-reset request flag.
- `tx`  out  1  UART 8N1 line, LSB first, idles high.
- `busy`  out  1  high while a frame is on the line.
- `frames_sent`  out  16  count of completed frames; wraps from 0xFFFF to 0.

## Operation
- **Frame format:** B0 = 0xA5 (sync); B1 = {reset_Pos, 6'b0, dir[8]}; B2 = dir[7:0]; B3 = B1 ^ B2.
- **Per-byte line sequence:** start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly `DIV` cycles.
- **States:** IDLE → START → DATA (8 bits) → STOP.
  - After STOP: byte index < 3 → START with index+1; index = 3 → IDLE.
- **Trigger, evaluated only in IDLE:**
  - Fires when `sent_valid` = 0, OR {reset_Pos_Ard, targetDirection_Ard} ≠ the last-sent snapshot, OR `refresh_cnt` = REFRESH_CYCLES−1.
  - On trigger, the inputs are latched into the snapshot and `sent_valid` is set to 1.
- **Input stability:** the snapshot is the only source for B1–B3. Input changes during a frame do not alter the frame in flight. They are evaluated against the snapshot at the next IDLE cycle.
- **Refresh counter (`refresh_cnt`):**
  - Cleared to 0 on the trigger cycle.
  - Increments every cycle otherwise.
  - Saturates at REFRESH_CYCLES−1.
- **`frames_sent`** increments on the last cycle of B3's stop bit.
- **Reset (`reset_n` = 0), including mid-frame; takes effect at the next clock edge:**
  - `tx` = 1, `busy` = 0, `frames_sent` = 0.
  - State = IDLE, byte index = 0, baud counter = 0, `refresh_cnt` = 0.
  - `sent_valid` = 0, snapshot = 0.
  - Any partial frame is abandoned. A full frame starts on the first cycle after release.

## Timing
- **Latency:** trigger detected in IDLE at cycle N → `tx` falls (start bit of B0) and `busy` rises at cycle N+1.
- **Frame length:** 40·`DIV` cycles. `busy` is high on every one of those cycles and falls at cycle N+1+40·DIV.
- **Back-to-back frames:**
  - At least one IDLE cycle separates consecutive frames, so the minimum frame period is 40·DIV+1 cycles.
  - If the inputs change during a frame, the next frame starts exactly one cycle after `busy` falls.
- **Keep-alive:**
  - With inputs constant, successive frame starts are REFRESH_CYCLES cycles apart, provided REFRESH_CYCLES > 40·DIV.
  - Otherwise frames run back to back, each followed by one IDLE cycle.
- **Simultaneous change and refresh expiry:** produce one frame, not two.
- **Bit-boundary sampling:** the bit shown on `tx` changes only on baud-counter wrap. No glitches occur within a bit period.

## Test plan
Use bench parameters CLK_HZ=1_000_000, BAUD=250_000 (DIV=4), REFRESH_CYCLES=1000.

1. **Post-reset frame:** release reset with dir=300, reset_Pos=0.
   - `tx` falls on the next cycle.
   - Decoded bytes are A5, 01, 2C, 2D.
   - `busy` is high for 160 cycles; `frames_sent`=1.
2. **Change-driven frame:** in IDLE, set reset_Pos=1 with dir=300.
   - Frame A5, 81, 2C, AD starts 1 cycle after the trigger cycle.
   - With no further change, the next frame starts 1000 cycles after this one.
3. **Mid-frame change:** change dir 300→5 during the B1 start bit.
   - The current frame is still A5, 01, 2C, 2D.
   - The next frame, A5, 00, 05, 05, starts one cycle after `busy` falls.
4. **Keep-alive:** hold the inputs constant for 5000 cycles after the first frame.
   - Frame starts are spaced exactly 1000 cycles apart, with identical payloads.
   - `frames_sent` increments by 1 per frame.
5. **Reset mid-frame:** assert `reset_n`=0 for 3 cycles during B2's data bits.
   - `tx`=1 and `busy`=0 from the next edge; `frames_sent`=0.
   - After release, a complete frame is resent.
6. **Counter wrap:** preload or run to `frames_sent`=0xFFFF. The next completed frame reads 0x0000.
